stopwatch_ctrl: RTL and testbench

Control FSM that sequences the stopwatch ticker from four debounced push-button levels. Generates the ticker's PAUSE, LOAD and clear strobes, detects saturation at 59:59:99, captures lap splits, and selects live or frozen time for the display path. Sits between the button debouncers and the ticker/7-segment formatter, entirely in the clk_2MHz domain.

---
 rtl/stopwatch_pkg.sv | 43 ++++
 rtl/stopwatch_ctrl_btn_edge.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch control block:
//               FSM state encoding, button event encoding, field limits and
//               a helper that flags the 59:59:99 saturation point.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // State codes are visible on the state output, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // paused, cleared
    ST_RUN  = 3'd1,  // counting
    ST_STOP = 3'd2,  // paused, nonzero
    ST_LAP  = 3'd3,  // counting, display frozen on lap split
    ST_SAT  = 3'd4   // paused at 59:59:99
  } sw_state_t;

  // Single winning button event per cycle after priority resolution.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_CLEAR = 3'd1,
    EV_LOAD  = 3'd2,
    EV_START = 3'd3,
    EV_LAP   = 3'd4
  } sw_event_t;

  localparam logic [6:0] MAX_MM  = 7'd59;
  localparam logic [6:0] MAX_SS  = 7'd59;
  localparam logic [6:0] MAX_MS  = 7'd99;
  localparam logic [3:0] LAP_MAX = 4'd15;

  // True when the live time sits exactly on the last representable value.
  function automatic logic is_saturated(input logic [6:0] mm,
                                        input logic [6:0] ss,
                                        input logic [6:0] ms);
    return (mm == MAX_MM) && (ss == MAX_SS) && (ms == MAX_MS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Rising-edge detector for one debounced button level. Emits a
//               one-cycle press pulse on the first high sample after a low.
// Ports       : clk   - system clock
//               rst   - synchronous active-high reset (clears previous level)
//               level - debounced button level
//               press - one-cycle pulse, level & ~previous level
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level <= 1'b0;
    end else begin
      prev_level <= level;
    end
  end

  // A held button produces a single pulse; a new press needs a low sample.
  assign press = level & ~prev_level;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch control FSM. Turns four debounced button levels
//               into ticker PAUSE / LOAD / clear strobes, detects saturation
//               at 59:59:99, captures lap splits and selects live or frozen
//               time for the display.
// Ports       : clk_2MHz, reset          - clock, sync active-high reset
//               btn_start/lap/clear/load - debounced button levels
//               curMM, curSS, curMS      - live ticker time
//               PAUSE                    - 1 = ticker holds count
//               LOAD                     - one-cycle preset load strobe
//               tick_clr                 - one-cycle ticker clear strobe
//               dispMM, dispSS, dispMS   - time shown on the display
//               lap_count                - splits taken, saturates at 15
//               state                    - current FSM state code
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic       clk_2MHz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       btn_load,
  input  logic [6:0] curMM,
  input  logic [6:0] curSS,
  input  logic [6:0] curMS,
  output logic       PAUSE,
  output logic       LOAD,
  output logic       tick_clr,
  output logic [6:0] dispMM,
  output logic [6:0] dispSS,
  output logic [6:0] dispMS,
  output logic [3:0] lap_count,
  output logic [2:0] state
);

  // --------------------------------------------------------------------------
  // Button edge detection
  // --------------------------------------------------------------------------
  logic press_start;
  logic press_lap;
  logic press_clear;
  logic press_load;

  btn_edge u_edge_start (.clk(clk_2MHz), .rst(reset), .level(btn_start), .press(press_start));
  btn_edge u_edge_lap   (.clk(clk_2MHz), .rst(reset), .level(btn_lap),   .press(press_lap));
  btn_edge u_edge_clear (.clk(clk_2MHz), .rst(reset), .level(btn_clear), .press(press_clear));
  btn_edge u_edge_load  (.clk(clk_2MHz), .rst(reset), .level(btn_load),  .press(press_load));

  // --------------------------------------------------------------------------
  // Priority resolution: only the highest-ranked press is considered; lower
  // ones in the same cycle are discarded even if the winner is ignored.
  // --------------------------------------------------------------------------
  sw_event_t event_sel;

  always_comb begin
    event_sel = EV_NONE;
    if (press_clear) begin
      event_sel = EV_CLEAR;
    end else if (press_load) begin
      event_sel = EV_LOAD;
    end else if (press_start) begin
      event_sel = EV_START;
    end else if (press_lap) begin
      event_sel = EV_LAP;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  sw_state_t fsm_state;
  sw_state_t state_nxt;
  logic      load_nxt;
  logic      clr_nxt;
  logic      lap_capture;
  logic      event_acted;
  logic      running;
  logic      at_max;

  assign running = (fsm_state == ST_RUN) || (fsm_state == ST_LAP);
  assign at_max  = is_saturated(curMM, curSS, curMS);

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      fsm_state <= ST_IDLE;
    end else begin
      fsm_state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = fsm_state;
    load_nxt    = 1'b0;
    clr_nxt     = 1'b0;
    lap_capture = 1'b0;
    event_acted = 1'b0;

    case (event_sel)
      EV_CLEAR: begin
        state_nxt   = ST_IDLE;
        clr_nxt     = 1'b1;
        event_acted = 1'b1;
      end
      EV_LOAD: begin
        // Loading a running ticker would corrupt the count; only paused states.
        if ((fsm_state == ST_IDLE) || (fsm_state == ST_STOP) || (fsm_state == ST_SAT)) begin
          state_nxt   = ST_STOP;
          load_nxt    = 1'b1;
          event_acted = 1'b1;
        end
      end
      EV_START: begin
        case (fsm_state)
          ST_IDLE, ST_STOP: begin
            state_nxt   = ST_RUN;
            event_acted = 1'b1;
          end
          ST_RUN, ST_LAP: begin
            state_nxt   = ST_STOP;
            event_acted = 1'b1;
          end
          default: ;
        endcase
      end
      EV_LAP: begin
        if (running) begin
          state_nxt   = ST_LAP;
          lap_capture = 1'b1;
          event_acted = 1'b1;
        end
      end
      default: ;
    endcase

    // A press that actually does something wins over saturation.
    if (!event_acted && running && at_max) begin
      state_nxt = ST_SAT;
    end

    // Recover from any unused encoding.
    if (!(fsm_state inside {ST_IDLE, ST_RUN, ST_STOP, ST_LAP, ST_SAT})) begin
      state_nxt = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Registered strobes, lap registers and lap counter
  // --------------------------------------------------------------------------
  logic [6:0] lap_mm;
  logic [6:0] lap_ss;
  logic [6:0] lap_ms;
  logic [3:0] lap_cnt;
  logic       load_q;
  logic       clr_q;

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      lap_mm  <= 7'd0;
      lap_ss  <= 7'd0;
      lap_ms  <= 7'd0;
      lap_cnt <= 4'd0;
    end else begin
      // Clear and load come from mutually exclusive events, so the two
      // strobes can never be high together.
      load_q <= load_nxt;
      clr_q  <= clr_nxt;
      if (clr_nxt) begin
        lap_mm  <= 7'd0;
        lap_ss  <= 7'd0;
        lap_ms  <= 7'd0;
        lap_cnt <= 4'd0;
      end else if (lap_capture) begin
        lap_mm <= curMM;
        lap_ss <= curSS;
        lap_ms <= curMS;
        if (lap_cnt != LAP_MAX) begin
          lap_cnt <= lap_cnt + 4'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign LOAD      = load_q;
  assign tick_clr  = clr_q;
  assign PAUSE     = ~running;
  assign lap_count = lap_cnt;
  assign state     = fsm_state;

  // Out-of-range live values pass straight through to the display.
  always_comb begin
    dispMM = curMM;
    dispSS = curSS;
    dispMS = curMS;
    if (fsm_state == ST_LAP) begin
      dispMM = lap_mm;
      dispSS = lap_ss;
      dispMS = lap_ms;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl. Expected output
//               snapshots are queued as stimulus is applied and popped and
//               compared after each clock edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_STOP = 3'd2;
  localparam logic [2:0] S_LAP  = 3'd3;
  localparam logic [2:0] S_SAT  = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_lap, btn_clear, btn_load;
  logic [6:0] curMM, curSS, curMS;
  logic       PAUSE, LOAD, tick_clr;
  logic [6:0] dispMM, dispSS, dispMS;
  logic [3:0] lap_count;
  logic [2:0] state;

  always #250 clk = ~clk;

  stopwatch_ctrl dut (
    .clk_2MHz (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_lap  (btn_lap),
    .btn_clear(btn_clear),
    .btn_load (btn_load),
    .curMM    (curMM),
    .curSS    (curSS),
    .curMS    (curMS),
    .PAUSE    (PAUSE),
    .LOAD     (LOAD),
    .tick_clr (tick_clr),
    .dispMM   (dispMM),
    .dispSS   (dispSS),
    .dispMS   (dispMS),
    .lap_count(lap_count),
    .state    (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pause;
    logic       load;
    logic       clr;
    logic [3:0] lc;
    logic [6:0] mm;
    logic [6:0] ss;
    logic [6:0] ms;
  } obs_t;

  typedef struct {
    string name;
    obs_t  o;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t got;
  exp_t e;

  function automatic obs_t sample();
    return {state, PAUSE, LOAD, tick_clr, lap_count, dispMM, dispSS, dispMS};
  endfunction

  // Queue the outputs required after the coming edge. PAUSE is high exactly
  // in the paused states IDLE, STOP and SAT.
  task automatic push_exp(input string nm, input logic [2:0] st, input logic ld,
                          input logic cl, input logic [3:0] lc,
                          input logic [6:0] mm, input logic [6:0] ss, input logic [6:0] ms);
    exp_t x;
    x.name = nm;
    x.o    = {st, (st == S_IDLE) || (st == S_STOP) || (st == S_SAT), ld, cl, lc, mm, ss, ms};
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input logic [6:0] mm, input logic [6:0] ss, input logic [6:0] ms);
    curMM = mm; curSS = ss; curMS = ms;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    set_cur(7'd100, 7'd127, 7'd5);
    push_exp("reset_asserted", S_IDLE, 0, 0, 4'd0, 7'd100, 7'd127, 7'd5);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    reset = 1'b0;
    push_exp("reset_released", S_IDLE, 0, 0, 4'd0, 7'd100, 7'd127, 7'd5);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    set_cur(7'd0, 7'd0, 7'd0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_start_hold();
    btn_start = 1'b1;
    push_exp("start_press", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    for (int i = 0; i < 100; i++) begin
      push_exp("start_held", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
      tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
      if (got !== e.o) begin n_bad++; $display("FAIL %s[%0d]: got %h required %h", e.name, i, got, e.o); end
    end
    btn_start = 1'b0;
    push_exp("start_release", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b1;
    push_exp("start_repress_stop", S_STOP, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    push_exp("stop_release", S_STOP, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lap();
    logic [3:0] lc;
    btn_start = 1'b1;
    push_exp("lap_setup_run", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    set_cur(7'd1, 7'd23, 7'd45);
    btn_lap = 1'b1;
    push_exp("lap_first", S_LAP, 0, 0, 4'd1, 7'd1, 7'd23, 7'd45);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_lap = 1'b0;
    set_cur(7'd1, 7'd24, 7'd0);
    push_exp("lap_frozen", S_LAP, 0, 0, 4'd1, 7'd1, 7'd23, 7'd45);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    for (int i = 0; i < 16; i++) begin
      lc = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      set_cur(7'd2, 7'(i), 7'(i + 10));
      btn_lap = 1'b1;
      push_exp("lap_repeat", S_LAP, 0, 0, lc, 7'd2, 7'(i), 7'(i + 10));
      tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
      if (got !== e.o) begin n_bad++; $display("FAIL %s[%0d]: got %h required %h", e.name, i, got, e.o); end
      btn_lap = 1'b0;
      set_cur(7'd3, 7'd0, 7'd0);
      push_exp("lap_repeat_hold", S_LAP, 0, 0, lc, 7'd2, 7'(i), 7'(i + 10));
      tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
      if (got !== e.o) begin n_bad++; $display("FAIL %s[%0d]: got %h required %h", e.name, i, got, e.o); end
    end
    btn_start = 1'b1;
    push_exp("lap_to_stop", S_STOP, 0, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    push_exp("lap_stop_release", S_STOP, 0, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load();
    btn_load = 1'b1;
    push_exp("load_in_stop", S_STOP, 1, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    push_exp("load_held_one_cycle", S_STOP, 0, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_load  = 1'b0;
    btn_start = 1'b1;
    push_exp("load_setup_run", S_RUN, 0, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    btn_load  = 1'b1;
    push_exp("load_in_run_ignored", S_RUN, 0, 0, 4'd15, 7'd3, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_load = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_saturation();
    set_cur(7'd59, 7'd59, 7'd99);
    push_exp("sat_enter", S_SAT, 0, 0, 4'd15, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b1;
    push_exp("sat_start_ignored", S_SAT, 0, 0, 4'd15, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    btn_clear = 1'b1;
    push_exp("sat_clear", S_IDLE, 0, 1, 4'd0, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    push_exp("clear_one_cycle", S_IDLE, 0, 0, 4'd0, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_clear = 1'b0;
    set_cur(7'd0, 7'd0, 7'd0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_sat_press_precedence();
    btn_start = 1'b1;
    push_exp("prec_setup_run", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    push_exp("prec_release", S_RUN, 0, 0, 4'd0, 7'd0, 7'd0, 7'd0);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    set_cur(7'd59, 7'd59, 7'd99);
    btn_start = 1'b1;
    push_exp("prec_start_beats_sat", S_STOP, 0, 0, 4'd0, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    push_exp("prec_stays_stop", S_STOP, 0, 0, 4'd0, 7'd59, 7'd59, 7'd99);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    set_cur(7'd4, 7'd5, 7'd6);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simultaneous();
    btn_start = 1'b1;
    push_exp("simul_run", S_RUN, 0, 0, 4'd0, 7'd4, 7'd5, 7'd6);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    btn_lap   = 1'b1;
    push_exp("simul_lap", S_LAP, 0, 0, 4'd1, 7'd4, 7'd5, 7'd6);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_lap   = 1'b0;
    btn_start = 1'b1;
    push_exp("simul_stop", S_STOP, 0, 0, 4'd1, 7'd4, 7'd5, 7'd6);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    tick();
    btn_start = 1'b1;
    push_exp("simul_run_again", S_RUN, 0, 0, 4'd1, 7'd4, 7'd5, 7'd6);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_start = 1'b0;
    tick();
    set_cur(7'd7, 7'd8, 7'd9);
    btn_clear = 1'b1; btn_start = 1'b1; btn_lap = 1'b1;
    push_exp("simul_clear_wins", S_IDLE, 0, 1, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_clear = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    push_exp("simul_after", S_IDLE, 0, 0, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_lap = 1'b1;
    push_exp("lap_in_idle_ignored", S_IDLE, 0, 0, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_lap = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_during_load();
    btn_load = 1'b1;
    push_exp("rload_strobe", S_STOP, 1, 0, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    btn_load = 1'b0;
    reset    = 1'b1;
    push_exp("rload_reset_wins", S_IDLE, 0, 0, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
    reset = 1'b0;
    push_exp("rload_after", S_IDLE, 0, 0, 4'd0, 7'd7, 7'd8, 7'd9);
    tick(); e = exp_q.pop_front(); got = sample(); n_cmp++;
    if (got !== e.o) begin n_bad++; $display("FAIL %s: got %h required %h", e.name, got, e.o); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; btn_load = 1'b0;
    set_cur(7'd0, 7'd0, 7'd0);
    test_reset();
    test_start_hold();
    test_lap();
    test_load();
    test_saturation();
    test_sat_press_precedence();
    test_simultaneous();
    test_reset_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
